router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet transmitter for the 1x3 router input port. It accepts a packet request (destination address and length) and its payload bytes from a host-side stream, and buffers the whole packet. It then drives it onto the router input as header, payload and parity bytes, throttled by the router's `busy`. It sits between the traffic source (or testbench host) and the router top.

## Interface
Parameters:
- `GAP_CYCLES`, 2: idle cycles with `pkt_valid`=0 after each parity byte before the next request is accepted (1..15).

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `resetn`  in  1  synchronous, active-low reset
- `req_valid`  in  1  packet request valid
- `req_ready`  out  1  request accepted when high with `req_valid`
- `req_addr`  in  2  destination port 0..2; 3 is illegal
- `req_len`  in  6  payload length 1..63; 0 is illegal
- `req_err`  out  1  1-cycle pulse: request rejected
- `pl_valid`  in  1  payload byte valid
- `pl_ready`  out  1  payload byte accepted when high with `pl_valid`
- `pl_data`  in  8  payload byte
- `data_out`  out  8  byte to router `data_in`
- `pkt_valid`  out  1  high for header and payload, low for parity
- `busy`  in  1  router busy; a byte transfers on any edge where `busy`=0 in HEADER/PAYLOAD/PARITY
- `tx_active`  out  1  high in every state except IDLE
- `tx_done`  out  1  1-cycle pulse after the parity byte transfers
- `tx_parity`  out  8  parity of the last completed packet; holds until the next `tx_done`

## Operation
- Header byte = {`req_len`[5:0], `req_addr`[1:0]}. Parity = XOR of the header and all payload bytes.
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `req_ready`=1, `pl_ready`=0.
  - On `req_valid`, a request with len=0 or addr=3 pulses `req_err` on the next cycle. The block stays in IDLE and nothing is transmitted.
  - Otherwise the header is latched, parity is set to the header, count is cleared, and the FSM goes to FILL.
- FILL: `pl_ready` = (count < len). Each accepted byte is written to `buf[count]`, parity ^= byte, and count++. The edge that accepts byte len moves the FSM to HEADER. `pl_valid` gaps simply stall FILL (store-and-forward).
- HEADER: `data_out`=header, `pkt_valid`=1. If `busy`=0, `rd_ptr` is cleared and the FSM goes to PAYLOAD. Otherwise it holds.
- PAYLOAD: `data_out`=`buf[rd_ptr]`, `pkt_valid`=1. If `busy`=0, `rd_ptr` increments; after byte len the FSM goes to PARITY. Otherwise it holds.
- PARITY: `data_out`=parity, `pkt_valid`=0. If `busy`=0, the FSM goes to GAP, `tx_parity` is loaded and `tx_done` pulses.
- GAP: `pkt_valid`=0, `data_out`=0. Counts GAP_CYCLES, then returns to IDLE.
- `req_ready`=0 and `pl_ready`=0 outside IDLE and FILL respectively. `pl_valid` in other states is ignored.
- `data_out` and `pkt_valid` depend only on state and registers, never combinationally on `busy`, so no loop forms with the router FSM.
- `busy` held high holds `data_out`/`pkt_valid` stable indefinitely, with no timeout. There is no abort input; only `resetn` recovers.

## Timing
- Reset values: state IDLE, `req_ready`=1 (combinational from IDLE), `pl_ready`=0, `req_err`=0, `data_out`=0, `pkt_valid`=0, `tx_active`=0, `tx_done`=0, `tx_parity`=0. Counters are zero; buffer contents are don't-care.
- Reset mid-packet: the packet is discarded, and the first cycle after reset shows the reset values above.
- Request accepted at edge t: `pl_ready`=1 from cycle t+1.
- Last payload byte accepted at edge u: header is driven in cycle u+1.
- With `busy`=0 throughout: HEADER 1 cycle, PAYLOAD len cycles, PARITY 1 cycle, GAP GAP_CYCLES cycles. IDLE follows at HEADER entry + len+2+GAP_CYCLES.
- `tx_done` is high in the first GAP cycle.
- Each `busy`=1 cycle in HEADER/PAYLOAD/PARITY adds exactly one cycle.

## Structure
- `router_pkg` holds:
  - the tx state enum
  - `ADDR_ILLEGAL` = 2'b11
  - `MAX_LEN` = 63
  - the header pack function `{len, addr}`; the router FSM already decodes `data_in[1:0]` as the address.
- Sub-module `router_tx_buf`: 64x8 register array with one write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`). No reset on the array.

## Test plan
- addr=1, len=3, payload 0x11,0x22,0x33, `busy`=0 → `data_out` 0x0D,0x11,0x22,0x33 with `pkt_valid`=1, then 0x0D with `pkt_valid`=0. `tx_done` pulses, `tx_parity`=0x0D.
- Same packet with `busy`=1 in the cycle after the header transfers → 0x11 held 2 cycles, no duplicate or drop, total one cycle longer.
- len=0 (addr=0), then addr=3 (len=5) → `req_err` pulses once each, `pkt_valid` stays 0, `req_ready` returns to 1.
- addr=2, len=63, payload 0..62 with random `pl_valid` gaps → header 0xFE emitted only after byte 62 is accepted, then 63 payload bytes in order, parity 0xC1.
- `resetn`=0 for one cycle mid-PAYLOAD → next cycle `pkt_valid`=0, `data_out`=0, `req_ready`=1. A following addr=0, len=1, payload 0xA5 packet sends 0x04, 0xA5, 0xA1.
- Two back-to-back requests → exactly GAP_CYCLES cycles of `pkt_valid`=0 after the first parity byte before the second header's earliest cycle plus its FILL time.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// The header packing matches the router FSM, which decodes data_in[1:0] as the address.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_e;

  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
  localparam int         MAX_LEN      = 63;

  function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 packet buffer: one synchronous write port, one asynchronous read port.
// The array has no reset; contents are only read after being written for the current packet.
module router_tx_buf (
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [64];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet transmitter for the router input port: buffers a whole
// packet, then sends header, payload and parity bytes, throttled by the router busy.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       req_err,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  input  logic       busy,
  output logic       tx_active,
  output logic       tx_done,
  output logic [7:0] tx_parity
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] header_q, header_d;
  logic [5:0] len_q, len_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] tx_parity_q, tx_parity_d;
  logic       req_err_q, req_err_d;
  logic       tx_done_q, tx_done_d;

  logic       req_bad;
  logic       pl_fire;
  logic       buf_we;
  logic [7:0] buf_rdata;

  assign req_bad = (req_len == 6'd0) || (req_addr == ADDR_ILLEGAL);
  assign pl_fire = (state_q == ST_FILL) && (cnt_q < len_q) && pl_valid;

  router_tx_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q),
    .wdata (pl_data),
    .raddr (rd_ptr_q),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    len_d       = len_q;
    parity_d    = parity_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    gap_d       = gap_q;
    tx_parity_d = tx_parity_q;
    req_err_d   = 1'b0;
    tx_done_d   = 1'b0;
    buf_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            req_err_d = 1'b1;
          end else begin
            header_d = pack_header(req_len, req_addr);
            len_d    = req_len;
            parity_d = pack_header(req_len, req_addr);
            cnt_d    = 6'd0;
            state_d  = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (pl_fire) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ pl_data;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q + 6'd1 == len_q) state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          rd_ptr_d = 6'd0;
          state_d  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          rd_ptr_d = rd_ptr_q + 6'd1;
          if (rd_ptr_q == len_q - 6'd1) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          tx_parity_d = parity_q;
          tx_done_d   = 1'b1;
          gap_d       = 4'd0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode state and registers only, so busy never reaches data_out/pkt_valid.
  always_comb begin
    data_out  = 8'h00;
    pkt_valid = 1'b0;
    unique case (state_q)
      ST_HEADER:  begin data_out = header_q;  pkt_valid = 1'b1; end
      ST_PAYLOAD: begin data_out = buf_rdata; pkt_valid = 1'b1; end
      ST_PARITY:  data_out = parity_q;
      default:    ;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign pl_ready  = (state_q == ST_FILL) && (cnt_q < len_q);
  assign tx_active = (state_q != ST_IDLE);
  assign req_err   = req_err_q;
  assign tx_done   = tx_done_q;
  assign tx_parity = tx_parity_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      rd_ptr_q    <= 6'd0;
      gap_q       <= 4'd0;
      tx_parity_q <= 8'h00;
      req_err_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      gap_q       <= gap_d;
      tx_parity_q <= tx_parity_d;
      req_err_q   <= req_err_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Packet data registers carry no reset; they are reloaded on every accepted request.
  always_ff @(posedge clk) begin
    header_q <= header_d;
    len_q    <= len_d;
    parity_q <= parity_d;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: packet framing, busy throttling, illegal
// requests, full-length packet with fill gaps, mid-packet reset and back-to-back packets.
module tb_router_pkt_tx;

  localparam int GAP = 2;

  logic       clk;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_err;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       busy;
  logic       tx_active;
  logic       tx_done;
  logic [7:0] tx_parity;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_cnt     = 0;
  int hdr_cyc     = 0;
  int par_cyc     = 0;
  logic [7:0] pl_mem [64];

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_err   (req_err),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .busy      (busy),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_parity (tx_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [1:0] a, input logic [5:0] l);
    chk1("req_ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic fill(input int l, input bit gaps);
    for (int i = 0; i < l; i++) begin
      if (gaps && (i % 3 == 1)) begin
        pl_valid = 1'b0;
        pl_data  = 8'hEE;
        chk1("pkt_valid_fill_gap", pkt_valid, 1'b0);
        tick();
      end
      chk1("pl_ready_fill", pl_ready, 1'b1);
      chk1("no_header_during_fill", pkt_valid, 1'b0);
      pl_valid = 1'b1;
      pl_data  = pl_mem[i];
      tick();
    end
    pl_valid = 1'b0;
  endtask

  // Checks the byte stream from HEADER entry through the GAP back to IDLE.
  task automatic xmit(input int l, input int busy_at, input logic [7:0] exp_hdr,
                      input logic [7:0] exp_par);
    logic [7:0] exp_b;
    logic       exp_v;
    int         idx;
    int         cyc;
    hdr_cyc = cyc_cnt;
    idx = 0;
    cyc = 0;
    chk1("pl_ready_in_header", pl_ready, 1'b0);
    while (idx < l + 2 && cyc < 200) begin
      busy = (cyc == busy_at);
      if (idx == 0) begin
        exp_b = exp_hdr; exp_v = 1'b1;
      end else if (idx <= l) begin
        exp_b = pl_mem[idx-1]; exp_v = 1'b1;
      end else begin
        exp_b = exp_par; exp_v = 1'b0;
      end
      chk8("data_out", data_out, exp_b);
      chk1("pkt_valid", pkt_valid, exp_v);
      chk1("tx_done_during_tx", tx_done, 1'b0);
      tick();
      if (!busy) idx++;
      cyc++;
    end
    busy = 1'b0;
    chk32("xmit_cycles", cyc, l + 2 + ((busy_at >= 0) ? 1 : 0));
    par_cyc = cyc_cnt;
    chk1("tx_done_pulse", tx_done, 1'b1);
    chk8("tx_parity", tx_parity, exp_par);
    chk8("data_out_gap", data_out, 8'h00);
    for (int g = 0; g < GAP; g++) begin
      chk1("tx_active_gap", tx_active, 1'b1);
      chk1("req_ready_gap", req_ready, 1'b0);
      chk1("pkt_valid_gap", pkt_valid, 1'b0);
      if (g > 0) chk1("tx_done_single", tx_done, 1'b0);
      tick();
    end
    chk1("req_ready_after_gap", req_ready, 1'b1);
    chk1("tx_active_after_gap", tx_active, 1'b0);
    chk8("tx_parity_hold", tx_parity, exp_par);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = 2'd0; req_len = 6'd0;
    pl_valid = 1'b0; pl_data = 8'h00; busy = 1'b0;
    tick();
    tick();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_pl_ready", pl_ready, 1'b0);
    chk1("rst_req_err", req_err, 1'b0);
    chk8("rst_data_out", data_out, 8'h00);
    chk1("rst_pkt_valid", pkt_valid, 1'b0);
    chk1("rst_tx_active", tx_active, 1'b0);
    chk1("rst_tx_done", tx_done, 1'b0);
    chk8("rst_tx_parity", tx_parity, 8'h00);
    resetn = 1'b1;
    tick();

    // addr=1 len=3: header 0x0D, parity 0x0D
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
    send_req(2'd1, 6'd3);
    chk1("pl_ready_after_req", pl_ready, 1'b1);
    chk1("tx_active_fill", tx_active, 1'b1);
    fill(3, 1'b0);
    xmit(3, -1, 8'h0D, 8'h0D);

    // same packet, busy in the cycle after the header transfers
    send_req(2'd1, 6'd3);
    fill(3, 1'b0);
    xmit(3, 1, 8'h0D, 8'h0D);

    // illegal requests
    send_req(2'd0, 6'd0);
    chk1("err_len0_pulse", req_err, 1'b1);
    chk1("err_len0_idle", tx_active, 1'b0);
    chk1("err_len0_pkt_valid", pkt_valid, 1'b0);
    chk1("err_len0_pl_ready", pl_ready, 1'b0);
    tick();
    chk1("err_len0_clear", req_err, 1'b0);
    send_req(2'd3, 6'd5);
    chk1("err_addr3_pulse", req_err, 1'b1);
    chk1("err_addr3_idle", tx_active, 1'b0);
    chk1("err_addr3_pkt_valid", pkt_valid, 1'b0);
    tick();
    chk1("err_addr3_clear", req_err, 1'b0);
    chk1("err_req_ready", req_ready, 1'b1);

    // addr=2 len=63 payload 0..62 with fill gaps: header 0xFE, parity 0xC1
    for (int i = 0; i < 63; i++) pl_mem[i] = 8'(i);
    send_req(2'd2, 6'd63);
    fill(63, 1'b1);
    xmit(63, -1, 8'hFE, 8'hC1);

    // back-to-back: A addr=0 len=2 (0x08/0x0B), B addr=2 len=2 (0x0A/0x3A)
    pl_mem[0] = 8'h01; pl_mem[1] = 8'h02;
    send_req(2'd0, 6'd2);
    fill(2, 1'b0);
    xmit(2, -1, 8'h08, 8'h0B);
    pl_mem[0] = 8'h10; pl_mem[1] = 8'h20;
    send_req(2'd2, 6'd2);
    fill(2, 1'b0);
    chk32("b2b_parity_to_header", cyc_cnt - par_cyc, GAP + 1 + 2);
    xmit(2, -1, 8'h0A, 8'h3A);

    // reset mid-PAYLOAD
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
    send_req(2'd1, 6'd3);
    fill(3, 1'b0);
    tick();
    chk8("mid_payload_byte0", data_out, 8'h11);
    tick();
    chk8("mid_payload_byte1", data_out, 8'h22);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk1("mrst_pkt_valid", pkt_valid, 1'b0);
    chk8("mrst_data_out", data_out, 8'h00);
    chk1("mrst_req_ready", req_ready, 1'b1);
    chk1("mrst_tx_active", tx_active, 1'b0);
    chk1("mrst_pl_ready", pl_ready, 1'b0);
    chk8("mrst_tx_parity", tx_parity, 8'h00);

    // addr=0 len=1 payload 0xA5: header 0x04, parity 0xA1
    pl_mem[0] = 8'hA5;
    send_req(2'd0, 6'd1);
    fill(1, 1'b0);
    xmit(1, -1, 8'h04, 8'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
